riscv_mmu_arbiter: RTL

- Shares the single MMU virtual-request port between the instruction-fetch and data-access requesters of one core.
- Provides round-robin arbitration with lock hold, back-to-back grants, a flush abort, and a watchdog that aborts hung transfers.
- Sits between the fetch/LSU units and the MMU. It captures the winning request, drives it to the MMU, and steers the MMU response back to the owner.

---
 rtl/riscv_mmu_arbiter_pkg.sv | 26 ++
 rtl/riscv_mmu_arbiter_if.sv | 44 ++++
 rtl/riscv_arb_rr2.sv | 35 +++
 rtl/riscv_mmu_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/riscv_mmu_arbiter_pkg.sv
// Shared types for the fetch/data MMU request arbiter: FSM state, owner and
// the captured virtual-request payload.
package riscv_mmu_arbiter_pkg;

    localparam int unsigned MMU_XLEN = 64;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [MMU_XLEN-1:0] adr;
        logic [2:0]          size;
        logic                lock;
        logic [2:0]          prot;
        logic                we;
        logic [MMU_XLEN-1:0] d;
    } mmu_vreq_t;

endpackage

// File: rtl/riscv_mmu_arbiter_if.sv
// Requester and MMU-side signals of the arbiter; slave is the arbiter's view,
// master is the view of the surrounding fetch/LSU/MMU logic.
interface riscv_mmu_arbiter_if #(
    parameter int unsigned XLEN = 64
);
    logic            ireq_i,  dreq_i;
    logic [XLEN-1:0] iadr_i,  dadr_i;
    logic [2:0]      isize_i, dsize_i;
    logic            ilock_i, dlock_i;
    logic [2:0]      iprot_i, dprot_i;
    logic            iwe_i,   dwe_i;
    logic [XLEN-1:0] id_i,    dd_i;
    logic [XLEN-1:0] iq_o,    dq_o;
    logic            iack_o,  dack_o;
    logic            ierr_o,  derr_o;

    logic            vreq_o;
    logic [XLEN-1:0] vadr_o;
    logic [2:0]      vsize_o;
    logic            vlock_o;
    logic [2:0]      vprot_o;
    logic            vwe_o;
    logic [XLEN-1:0] vd_o;
    logic [XLEN-1:0] vq_i;
    logic            vack_i;
    logic            vclr_o;

    modport slave (
        input  ireq_i, iadr_i, isize_i, ilock_i, iprot_i, iwe_i, id_i,
        input  dreq_i, dadr_i, dsize_i, dlock_i, dprot_i, dwe_i, dd_i,
        output iq_o, iack_o, ierr_o, dq_o, dack_o, derr_o,
        output vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o, vclr_o,
        input  vq_i, vack_i
    );

    modport master (
        output ireq_i, iadr_i, isize_i, ilock_i, iprot_i, iwe_i, id_i,
        output dreq_i, dadr_i, dsize_i, dlock_i, dprot_i, dwe_i, dd_i,
        input  iq_o, iack_o, ierr_o, dq_o, dack_o, derr_o,
        input  vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o, vclr_o,
        output vq_i, vack_i
    );

endinterface

// File: rtl/riscv_arb_rr2.sv
// Two-way round-robin picker: the locked, still-requesting owner keeps the
// grant; otherwise a single requester wins and a tie goes to the one not last.
module riscv_arb_rr2
    import riscv_mmu_arbiter_pkg::*;
(
    input  logic       ireq_i,
    input  logic       dreq_i,
    input  logic       ilock_i,
    input  logic       dlock_i,
    input  logic       lock_en_i,
    input  arb_owner_t owner_i,
    input  arb_owner_t last_i,
    output logic       valid_o,
    output arb_owner_t gnt_o
);

    logic hold;

    assign hold = lock_en_i &&
                  ((owner_i == OWN_I) ? (ireq_i && ilock_i) : (dreq_i && dlock_i));

    always_comb begin
        valid_o = 1'b1;
        gnt_o   = owner_i;
        if (!hold) begin
            case ({dreq_i, ireq_i})
                2'b01:   gnt_o = OWN_I;
                2'b10:   gnt_o = OWN_D;
                2'b11:   gnt_o = (last_i == OWN_I) ? OWN_D : OWN_I;
                default: valid_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mmu_arbiter.sv
// Shares the MMU virtual-request port between instruction fetch and data
// access, with lock hold, back-to-back grants, flush abort and a watchdog.
module riscv_mmu_arbiter
    import riscv_mmu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = MMU_XLEN,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNTW    = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    riscv_mmu_arbiter_if.slave bus
);

    arb_state_t      state_q;
    arb_owner_t      owner_q;
    arb_owner_t      last_q;
    logic [CNTW-1:0] cnt_q;
    mmu_vreq_t       cap_q;

    mmu_vreq_t       ifields;
    mmu_vreq_t       dfields;
    logic            gnt_valid;
    arb_owner_t      gnt;
    logic            do_grant;
    logic            at_limit;
    logic            timeout_hit;
    logic [XLEN-1:0] rdata;

    always_comb begin
        ifields      = '0;
        ifields.adr  = bus.iadr_i;
        ifields.size = bus.isize_i;
        ifields.lock = bus.ilock_i;
        ifields.prot = bus.iprot_i;
        ifields.we   = bus.iwe_i;
        ifields.d    = bus.id_i;
        dfields      = '0;
        dfields.adr  = bus.dadr_i;
        dfields.size = bus.dsize_i;
        dfields.lock = bus.dlock_i;
        dfields.prot = bus.dprot_i;
        dfields.we   = bus.dwe_i;
        dfields.d    = bus.dd_i;
    end

    // Lock hold only applies on an ack in BUSY; after IDLE the lock is gone.
    riscv_arb_rr2 u_rr2 (
        .ireq_i    (bus.ireq_i),
        .dreq_i    (bus.dreq_i),
        .ilock_i   (bus.ilock_i),
        .dlock_i   (bus.dlock_i),
        .lock_en_i (state_q == ARB_BUSY),
        .owner_i   (owner_q),
        .last_i    (last_q),
        .valid_o   (gnt_valid),
        .gnt_o     (gnt)
    );

    assign do_grant    = gnt_valid && ((state_q == ARB_IDLE) || bus.vack_i);
    assign at_limit    = (TIMEOUT != 0) && (cnt_q == CNTW'(TIMEOUT - 1));
    assign timeout_hit = (state_q == ARB_BUSY) && !bus.vack_i && at_limit && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else if (clr_i) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else if (do_grant) begin
            state_q <= ARB_BUSY;
            owner_q <= gnt;
            last_q  <= gnt;
            cnt_q   <= '0;
            cap_q   <= (gnt == OWN_D) ? dfields : ifields;
        end else if (state_q == ARB_BUSY) begin
            if (bus.vack_i || timeout_hit) begin
                state_q <= ARB_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.vreq_o  = (state_q == ARB_BUSY);
    assign bus.vadr_o  = cap_q.adr;
    assign bus.vsize_o = cap_q.size;
    assign bus.vlock_o = cap_q.lock;
    assign bus.vprot_o = cap_q.prot;
    assign bus.vwe_o   = cap_q.we;
    assign bus.vd_o    = cap_q.d;
    assign bus.vclr_o  = clr_i || timeout_hit;

    // Response steering is purely combinational: no added latency.
    assign rdata      = bus.vq_i;
    assign bus.iq_o   = rdata;
    assign bus.dq_o   = rdata;
    assign bus.iack_o = bus.vack_i && (owner_q == OWN_I);
    assign bus.dack_o = bus.vack_i && (owner_q == OWN_D);
    assign bus.ierr_o = timeout_hit && !clr_i && (owner_q == OWN_I);
    assign bus.derr_o = timeout_hit && !clr_i && (owner_q == OWN_D);

endmodule
